// File: rtl/cl_vled_arbiter.sv
// Virtual LED arbiter: round-robin ownership of the 16-bit vLED bus with a minimum
// display time, preemption under contention, and a vDIP[15] override that mirrors the DIPs.
module cl_vled_arbiter #(
    parameter int  NUM_REQ  = 4,
    parameter int  MIN_HOLD = 4,
    parameter int  MAX_HOLD = 1024,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    input  logic [15:0]           sh_cl_status_vdip,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] led_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic [15:0]           cl_sh_status_vled,
    output logic                  owner_valid,
    output logic [ID_W-1:0]       owner_id,
    output logic                  override_active,
    output logic [15:0]           preempt_cnt
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_OVERRIDE
    } state_t;

    // Reset asserts asynchronously and releases two clocks after rst_main_n rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    logic [15:0]        vdip_meta_q, vdip_meta_d;
    logic [15:0]        vdip_sync_q, vdip_sync_d;
    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [15:0]        vled_q, vled_d;
    logic               owner_valid_q, owner_valid_d;
    logic [ID_W-1:0]    owner_id_q, owner_id_d;
    logic               override_q, override_d;
    logic [15:0]        preempt_cnt_q, preempt_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic [NUM_REQ-1:0] req_scan;
    logic [ID_W-1:0]    scan_idx;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W-1:0]    rr_next;
    logic [15:0]        owner_led;
    logic               owner_req;

    // The current owner is masked out, so win_found also means "another request is pending".
    always_comb begin
        req_scan  = req & ~grant_q;
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && req_scan[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
        win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
        rr_next    = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    always_comb begin
        owner_req = |(req & grant_q);
        owner_led = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_id_q == ID_W'(i)) begin
                owner_led = led_data[16*i +: 16];
            end
        end
    end

    logic release_ok, preempt_ok, do_grant;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        vdip_meta_d   = sh_cl_status_vdip;
        vdip_sync_d   = vdip_meta_q;
        state_d       = state_q;
        grant_d       = grant_q;
        vled_d        = vled_q;
        owner_valid_d = owner_valid_q;
        owner_id_d    = owner_id_q;
        override_d    = override_q;
        preempt_cnt_d = preempt_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        do_grant      = 1'b0;
        release_ok    = (hold_cnt_q >= HOLD_W'(MIN_HOLD)) && !owner_req;
        preempt_ok    = (hold_cnt_q >= HOLD_W'(MAX_HOLD)) && owner_req && win_found;

        if (vdip_sync_q[15]) begin
            state_d       = ST_OVERRIDE;
            grant_d       = '0;
            owner_valid_d = 1'b0;
            override_d    = 1'b1;
            vled_d        = vdip_sync_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    do_grant = win_found;
                end
                ST_GRANT: begin
                    vled_d = owner_led;
                    if (hold_cnt_q < HOLD_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                    if (release_ok || preempt_ok) begin
                        if (preempt_ok && (preempt_cnt_q != 16'hFFFF)) begin
                            preempt_cnt_d = preempt_cnt_q + 1'b1;
                        end
                        if (win_found) begin
                            do_grant = 1'b1;
                        end else begin
                            state_d       = ST_IDLE;
                            grant_d       = '0;
                            owner_valid_d = 1'b0;
                        end
                    end
                end
                ST_OVERRIDE: begin
                    state_d    = ST_IDLE;
                    override_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (do_grant) begin
            state_d       = ST_GRANT;
            grant_d       = win_onehot;
            owner_valid_d = 1'b1;
            owner_id_d    = win_id;
            rr_ptr_d      = rr_next;
            hold_cnt_d    = HOLD_W'(1);
        end
    end

    // NOTE: clocked state uses <= only, so every flop samples the pre-edge value of its peers.
    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            vdip_meta_q   <= '0;
            vdip_sync_q   <= '0;
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            vled_q        <= '0;
            owner_valid_q <= 1'b0;
            owner_id_q    <= '0;
            override_q    <= 1'b0;
            preempt_cnt_q <= '0;
            rr_ptr_q      <= '0;
            hold_cnt_q    <= '0;
        end else begin
            vdip_meta_q   <= vdip_meta_d;
            vdip_sync_q   <= vdip_sync_d;
            state_q       <= state_d;
            grant_q       <= grant_d;
            vled_q        <= vled_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            override_q    <= override_d;
            preempt_cnt_q <= preempt_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant             = grant_q;
    assign cl_sh_status_vled = vled_q;
    assign owner_valid       = owner_valid_q;
    assign owner_id          = owner_id_q;
    assign override_active   = override_q;
    assign preempt_cnt       = preempt_cnt_q;

endmodule

// File: tb/tb_cl_vled_arbiter.sv
// Scoreboard bench for cl_vled_arbiter: directed stimulus queues the expected sequence of
// output changes; a negedge monitor pops one entry per change and checks value and duration.
module tb_cl_vled_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MIN_HOLD = 4;
    localparam int MAX_HOLD = 16;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n;
    logic [15:0] sh_cl_status_vdip;
    logic [3:0]  req;
    logic [63:0] led_data;
    logic [3:0]  grant;
    logic [15:0] cl_sh_status_vled;
    logic        owner_valid;
    logic [1:0]  owner_id;
    logic        override_active;
    logic [15:0] preempt_cnt;

    always #5 clk_main_a0 = ~clk_main_a0;

    cl_vled_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MIN_HOLD (MIN_HOLD),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk_main_a0       (clk_main_a0),
        .rst_main_n        (rst_main_n),
        .sh_cl_status_vdip (sh_cl_status_vdip),
        .req               (req),
        .led_data          (led_data),
        .grant             (grant),
        .cl_sh_status_vled (cl_sh_status_vled),
        .owner_valid       (owner_valid),
        .owner_id          (owner_id),
        .override_active   (override_active),
        .preempt_cnt       (preempt_cnt)
    );

    typedef struct {
        logic [3:0]  grant;
        logic        owner_valid;
        logic [1:0]  owner_id;
        logic        ovr;
        logic [15:0] pcnt;
        logic [15:0] vled;
        int          dur;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // dur = number of cycles this output state must persist (0 = not checked); vled is
    // checked one cycle after the change, once the LED register has caught up.
    task automatic expect_ev(input logic [3:0] g, input logic ov, input logic [1:0] id,
                             input logic ovr, input logic [15:0] pc, input logic [15:0] vl,
                             input int dur);
        exp_t e;
        e.grant = g; e.owner_valid = ov; e.owner_id = id; e.ovr = ovr;
        e.pcnt = pc; e.vled = vl; e.dur = dur;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_main_a0);
        #2;
    endtask

    initial begin : monitor_p
        exp_t        e;
        logic [23:0] prev, cur;
        int          run_len, dur_exp, ev_n;
        logic        vled_pend;
        logic [15:0] vled_exp;
        wait (rst_main_n === 1'b0);
        #1;
        prev = '0; run_len = 0; dur_exp = 0; ev_n = 0; vled_pend = 1'b0; vled_exp = '0;
        forever begin
            @(negedge clk_main_a0);
            if (vled_pend) begin
                check($sformatf("event%0d_vled", ev_n), 32'(cl_sh_status_vled), 32'(vled_exp));
                vled_pend = 1'b0;
            end
            cur = {grant, owner_valid, owner_id, override_active, preempt_cnt};
            if (cur !== prev) begin
                if (dur_exp != 0) begin
                    check($sformatf("event%0d_cycles", ev_n), 32'(run_len), 32'(dur_exp));
                end
                ev_n++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL event%0d_unexpected: got %h with no change expected", ev_n, cur);
                    dur_exp = 0;
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("event%0d_outputs", ev_n), 32'(cur),
                          32'({e.grant, e.owner_valid, e.owner_id, e.ovr, e.pcnt}));
                    vled_exp  = e.vled;
                    vled_pend = 1'b1;
                    dur_exp   = e.dur;
                end
                prev    = cur;
                run_len = 1;
            end else begin
                run_len++;
            end
        end
    end

    initial begin
        rst_main_n        = 1'b1;
        req               = 4'h0;
        sh_cl_status_vdip = 16'h0000;
        led_data          = {16'h4444, 16'hA5A5, 16'h2222, 16'h1111};
        #1;
        rst_main_n = 1'b0;
        req        = 4'hF;
        tick(3);
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_vled", 32'(cl_sh_status_vled), 32'h0);
        check("reset_preempt_cnt", 32'(preempt_cnt), 32'h0);
        check("reset_owner_valid", 32'(owner_valid), 32'h0);
        check("reset_owner_id", 32'(owner_id), 32'h0);
        check("reset_override", 32'(override_active), 32'h0);

        // Release from reset with all requests: requester 0 wins, holds MIN_HOLD, then idles.
        expect_ev(4'b0001, 1'b1, 2'd0, 1'b0, 16'd0, 16'h1111, 4);
        expect_ev(4'b0000, 1'b0, 2'd0, 1'b0, 16'd0, 16'h1111, 0);
        rst_main_n = 1'b1;
        tick(3); req = 4'h0;
        tick(8);

        // Single one-cycle request from requester 2 still holds MIN_HOLD cycles.
        expect_ev(4'b0100, 1'b1, 2'd2, 1'b0, 16'd0, 16'hA5A5, 4);
        expect_ev(4'b0000, 1'b0, 2'd2, 1'b0, 16'd0, 16'hA5A5, 0);
        req = 4'b0100;
        tick(1); req = 4'h0;
        tick(8);

        // Reset pulse during a grant to requester 1.
        expect_ev(4'b0010, 1'b1, 2'd1, 1'b0, 16'd0, 16'h2222, 2);
        expect_ev(4'b0000, 1'b0, 2'd0, 1'b0, 16'd0, 16'h0000, 0);
        req = 4'b0010;
        tick(3);
        rst_main_n = 1'b0;
        req        = 4'b1011;
        #1;
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_vled", 32'(cl_sh_status_vled), 32'h0);
        check("midrst_owner_valid", 32'(owner_valid), 32'h0);
        check("midrst_owner_id", 32'(owner_id), 32'h0);
        check("midrst_override", 32'(override_active), 32'h0);
        check("midrst_preempt_cnt", 32'(preempt_cnt), 32'h0);
        tick(2);

        // Round-robin 0,1,3,0 from a freshly reset pointer; each owner drops req after 4 cycles.
        expect_ev(4'b0001, 1'b1, 2'd0, 1'b0, 16'd0, 16'h1111, 4);
        expect_ev(4'b0010, 1'b1, 2'd1, 1'b0, 16'd0, 16'h2222, 4);
        expect_ev(4'b1000, 1'b1, 2'd3, 1'b0, 16'd0, 16'h4444, 4);
        expect_ev(4'b0001, 1'b1, 2'd0, 1'b0, 16'd0, 16'h1111, 4);
        expect_ev(4'b0000, 1'b0, 2'd0, 1'b0, 16'd0, 16'h1111, 0);
        rst_main_n = 1'b1;
        tick(6); req = 4'b1010;
        tick(1); req = 4'b1011;
        tick(3); req = 4'b1001;
        tick(1); req = 4'b1011;
        tick(3); req = 4'b0011;
        tick(1); req = 4'b0000;
        tick(8);

        // Preemption: requester 2 arrives in grant cycle 5 and takes over after MAX_HOLD.
        expect_ev(4'b0001, 1'b1, 2'd0, 1'b0, 16'd0, 16'h1111, 16);
        expect_ev(4'b0100, 1'b1, 2'd2, 1'b0, 16'd1, 16'hA5A5, 4);
        expect_ev(4'b0000, 1'b0, 2'd2, 1'b0, 16'd1, 16'hA5A5, 0);
        req = 4'b0001;
        tick(5); req = 4'b0101;
        tick(12); req = 4'b0000;
        tick(8);

        // Override while requester 1 owns; on exit the preserved pointer picks requester 3.
        expect_ev(4'b0010, 1'b1, 2'd1, 1'b0, 16'd1, 16'h2222, 4);
        expect_ev(4'b0000, 1'b0, 2'd1, 1'b1, 16'd1, 16'h8123, 6);
        expect_ev(4'b0000, 1'b0, 2'd1, 1'b0, 16'd1, 16'h8123, 1);
        expect_ev(4'b1000, 1'b1, 2'd3, 1'b0, 16'd1, 16'h4444, 4);
        expect_ev(4'b0000, 1'b0, 2'd3, 1'b0, 16'd1, 16'h4444, 0);
        req = 4'b0010;
        tick(2); sh_cl_status_vdip = 16'h8123;
        tick(4); req = 4'b1010;
        tick(2); sh_cl_status_vdip = 16'h0123;
        tick(4); req = 4'b0000;
        tick(8);

        // Lone owner keeps the grant past MAX_HOLD; a late competitor preempts at once.
        expect_ev(4'b0001, 1'b1, 2'd0, 1'b0, 16'd1, 16'h1111, 40);
        expect_ev(4'b0100, 1'b1, 2'd2, 1'b0, 16'd2, 16'hA5A5, 4);
        expect_ev(4'b0000, 1'b0, 2'd2, 1'b0, 16'd2, 16'hA5A5, 0);
        req = 4'b0001;
        tick(40); req = 4'b0101;
        tick(1); req = 4'b0000;
        tick(8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
